// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage.
//   MEM_DATA_W / MEM_DEST_W : default datapath and register-index widths.
//   *_WIDTH                 : bus widths of the stage interfaces at default widths.
//   mem_op_e                : load access-type encodings.
package mem_stage_pkg;

    localparam int MEM_DATA_W        = 32;
    localparam int MEM_DEST_W        = 5;

    localparam int TO_MEM_DATA_WIDTH = 74;
    localparam int TO_WB_DATA_WIDTH  = 70;
    localparam int MEM_FORWARD_WIDTH = 38;

    // Bit 2 set means zero-extend. Bits 1:0 give the size: 00 word, 01 byte, 10 half.
    typedef enum logic [2:0] {
        MEM_OP_W  = 3'b000,
        MEM_OP_B  = 3'b001,
        MEM_OP_H  = 3'b010,
        MEM_OP_BU = 3'b101,
        MEM_OP_HU = 3'b110
    } mem_op_e;

endpackage

// File: rtl/mem_stage_load_ext.sv
// mem_load_ext: combinational load-data select and extension.
// Ports:
//   mem_op    in  3       access type (mem_op_e encoding).
//   addr      in  2       low address bits of the access.
//   raw       in  DATA_W  word returned by the data SRAM (or the response buffer).
//   load_data out DATA_W  selected and sign- or zero-extended load value.
// Halves are selected by addr[1] only, so addr[0] has no effect on them.
// Unknown mem_op codes return the whole word.
module mem_load_ext
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        mem_op,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte/half lane select, then extension by access type.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = raw;

        case (addr)
            2'd0:    byte_s = raw[7:0];
            2'd1:    byte_s = raw[15:8];
            2'd2:    byte_s = raw[23:16];
            2'd3:    byte_s = raw[31:24];
            default: byte_s = raw[7:0];
        endcase

        if (addr[1]) begin
            half_s = raw[31:16];
        end else begin
            half_s = raw[15:0];
        end

        case (mem_op)
            MEM_OP_B:  load_data = {{(DATA_W-8){byte_s[7]}}, byte_s};
            MEM_OP_BU: load_data = {{(DATA_W-8){1'b0}}, byte_s};
            MEM_OP_H:  load_data = {{(DATA_W-16){half_s[15]}}, half_s};
            MEM_OP_HU: load_data = {{(DATA_W-16){1'b0}}, half_s};
            default:   load_data = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Build option: define MEM_LOAD_EXT_EN to enable byte/half load select and
// extension. Without it every load returns the full SRAM word.
// Ports:
//   clk, reset         clock and synchronous active-high reset.
//   EX_to_MEM_valid    upstream payload valid.
//   to_MEM_data        {pc, alu_result, res_from_mem, mem_op[2:0], dest, gr_we}.
//   MEM_allow_in       stage can accept a payload this cycle.
//   WB_allow_in        writeback can accept this cycle.
//   MEM_to_WB_valid    to_WB_data is valid.
//   to_WB_data         {pc, final_result, dest, gr_we}.
//   data_sram_data_ok  load data returned this cycle.
//   data_sram_rdata    load data.
//   MEM_forward        {MEM_dest, final_result, mem_busy} for decode bypass/stall.
// A one-entry buffer keeps load data that arrives while writeback is stalled.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int DEST_W = MEM_DEST_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       EX_to_MEM_valid,
    input  logic [2*DATA_W+DEST_W+4:0] to_MEM_data,
    output logic                       MEM_allow_in,
    input  logic                       WB_allow_in,
    output logic                       MEM_to_WB_valid,
    output logic [2*DATA_W+DEST_W:0]   to_WB_data,
    input  logic                       data_sram_data_ok,
    input  logic [DATA_W-1:0]          data_sram_rdata,
    output logic [DATA_W+DEST_W:0]     MEM_forward
);

    logic                       mem_valid_r;
    logic [2*DATA_W+DEST_W+4:0] payload_r;
    logic [DATA_W-1:0]          rdata_buf_r;
    logic                       rdata_buf_valid_r;

    logic [DATA_W-1:0] pc_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              res_from_mem_s;
    logic [2:0]        mem_op_s;
    logic [DEST_W-1:0] dest_s;
    logic              gr_we_s;

    logic              ready_go_s;
    logic              capture_s;
    logic              release_s;
    logic [DATA_W-1:0] raw_s;
    logic [DATA_W-1:0] load_data_s;
    logic [DATA_W-1:0] final_result_s;
    logic              mem_busy_s;
    logic [DEST_W-1:0] mem_dest_s;

    assign {pc_s, alu_result_s, res_from_mem_s, mem_op_s, dest_s, gr_we_s} = payload_r;

    // A load is ready once data arrives live or is already buffered.
    assign ready_go_s      = ~res_from_mem_s | data_sram_data_ok | rdata_buf_valid_r;
    assign MEM_allow_in    = ~mem_valid_r | (ready_go_s & WB_allow_in);
    assign MEM_to_WB_valid = mem_valid_r & ready_go_s;

    // Capture only when the response would otherwise be lost to a writeback stall.
    assign capture_s = mem_valid_r & res_from_mem_s & data_sram_data_ok
                     & ~rdata_buf_valid_r & ~WB_allow_in;
    assign release_s = MEM_to_WB_valid & WB_allow_in;

    // Buffered data takes priority; the SRAM may have moved on.
    assign raw_s = rdata_buf_valid_r ? rdata_buf_r : data_sram_rdata;

`ifdef MEM_LOAD_EXT_EN
    mem_load_ext #(
        .DATA_W    (DATA_W)
    ) u_load_ext (
        .mem_op    (mem_op_s),
        .addr      (alu_result_s[1:0]),
        .raw       (raw_s),
        .load_data (load_data_s)
    );
`else
    logic unused_mem_op_s;
    assign unused_mem_op_s = ^mem_op_s;
    assign load_data_s     = raw_s;
`endif

    assign final_result_s = res_from_mem_s ? load_data_s : alu_result_s;
    assign mem_dest_s     = dest_s & {DEST_W{mem_valid_r & gr_we_s}};
    assign mem_busy_s     = mem_valid_r & res_from_mem_s & ~ready_go_s;

    assign to_WB_data  = {pc_s, final_result_s, dest_s, gr_we_s};
    assign MEM_forward = {mem_dest_s, final_result_s, mem_busy_s};

    // Stage occupancy, payload capture and load-response buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_r       <= 1'b0;
            payload_r         <= '0;
            rdata_buf_r       <= '0;
            rdata_buf_valid_r <= 1'b0;
        end else begin
            if (MEM_allow_in) begin
                mem_valid_r <= EX_to_MEM_valid;
            end
            if (EX_to_MEM_valid && MEM_allow_in) begin
                payload_r <= to_MEM_data;
            end
            if (capture_s) begin
                rdata_buf_r       <= data_sram_rdata;
                rdata_buf_valid_r <= 1'b1;
            end else if (release_s) begin
                rdata_buf_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of writeback.
- Accepts the execute-stage payload through a valid/allow_in handshake.
- Waits for the data SRAM response on loads, then selects and extends load data by access type.
- Forwards its destination and result to decode, and passes a writeback payload onward.
- Holds a one-entry response buffer so load data is never lost while writeback stalls.

Parameters:
- DATA_W, 32, datapath/address width.
- DEST_W, 5, register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- EX_to_MEM_valid  in  1  upstream payload valid.
- to_MEM_data  in  74  {pc[31:0], alu_result[31:0], res_from_mem, mem_op[2:0], dest[4:0], gr_we}.
- MEM_allow_in  out  1  stage can accept this cycle.
- WB_allow_in  in  1  writeback can accept this cycle.
- MEM_to_WB_valid  out  1  payload to writeback valid.
- to_WB_data  out  70  {pc[31:0], final_result[31:0], dest[4:0], gr_we}.
- data_sram_data_ok  in  1  read data returned this cycle.
- data_sram_rdata  in  32  read data.
- MEM_forward  out  38  {MEM_dest[4:0], final_result[31:0], mem_busy}.

Behaviour:
- Reset values:
  - MEM_valid=0, payload register=0, rdata_buf=0, rdata_buf_valid=0.
  - Hence MEM_to_WB_valid=0, MEM_allow_in=1, MEM_forward=0.
- Handshake:
  - MEM_ready_go = ~res_from_mem | data_sram_data_ok | rdata_buf_valid.
  - MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in).
  - MEM_to_WB_valid = MEM_valid & MEM_ready_go.
  - If MEM_allow_in, MEM_valid <= EX_to_MEM_valid.
  - If EX_to_MEM_valid & MEM_allow_in, the payload register <= to_MEM_data.
- Latency:
  - Non-load: 1 cycle in stage, no bubble; back-to-back issue at full rate.
  - Load: leaves in the first cycle with data_ok or a buffered response, with WB_allow_in=1.
- Response buffer:
  - Capture condition: MEM_valid & res_from_mem & data_sram_data_ok & ~rdata_buf_valid & ~WB_allow_in.
  - On capture: rdata_buf <= rdata and rdata_buf_valid <= 1.
  - Clear condition: MEM_to_WB_valid & WB_allow_in.
  - The buffer takes priority over the live rdata.
  - data_ok while ~MEM_valid, on a non-load, or with the buffer already full is ignored.
- Load data select; raw = rdata_buf_valid ? rdata_buf : data_sram_rdata:
  - mem_op 000 ld.w: raw.
  - 001 ld.b: byte raw[8*addr[1:0] +: 8], sign-extended.
  - 101 ld.bu: same byte, zero-extended.
  - 010 ld.h: half raw[16*addr[1] +: 16], sign-extended.
  - 110 ld.hu: same half, zero-extended.
  - addr = alu_result[1:0]. addr[0] is ignored for halves; no misalignment check.
  - Other codes behave as ld.w.
- Result: final_result = res_from_mem ? load_data : alu_result.
- Forwarding:
  - MEM_dest = dest & {5{MEM_valid & gr_we}}.
  - mem_busy = MEM_valid & res_from_mem & ~MEM_ready_go. Decode stalls on a matching dest when mem_busy=1.
- Reset mid-load: MEM_valid and the buffer are cleared next edge. A late data_ok afterwards is ignored.

Optional Feature:
- Macro: MEM_LOAD_EXT_EN.
- Defined: full byte/half select and extension as above.
- Undefined: load_data = raw for every mem_op; the select/extension logic is absent.

Decomposition:
- constants.h gains:
  - to_MEM_data_width=74, to_WB_data_width=70, MEM_forward_width=38.
  - mem_op encodings: MEM_OP_W, MEM_OP_B, MEM_OP_H, MEM_OP_BU, MEM_OP_HU.
- One sub-module, mem_load_ext: combinational (mem_op, addr[1:0], raw) -> load_data. Instantiated only under MEM_LOAD_EXT_EN.

Test Plan:
- ld.w, addr 0x1000, data_ok in entry cycle, rdata 0xDEADBEEF, WB_allow_in=1 -> MEM_to_WB_valid=1 that cycle, final_result=0xDEADBEEF, mem_busy=0.
- rdata 0x80FF1234:
  - ld.b addr[1:0]=2 -> 0xFFFFFFFF.
  - ld.bu addr[1:0]=2 -> 0x000000FF.
  - ld.h addr[1:0]=2 -> 0xFFFF80FF.
  - ld.hu addr[1:0]=0 -> 0x00001234.
  - With the macro off, all four -> 0x80FF1234.
- Load, data_ok delayed 3 cycles -> MEM_allow_in=0, mem_busy=1, MEM_to_WB_valid=0 for 3 cycles; the 4th cycle delivers the data.
- data_ok with rdata 0x11111111 while WB_allow_in=0, rdata then changes to 0x22222222, WB_allow_in=1 two cycles later -> output 0x11111111; rdata_buf_valid clears after the transfer.
- Three back-to-back ALU ops (alu_result 1, 2, 3), WB_allow_in=1 -> results 1, 2, 3 on consecutive cycles. MEM_forward dest equals each dest, or 0 when gr_we=0.
- reset asserted while a load waits for data_ok, then data_ok=1 -> MEM_valid=0, MEM_to_WB_valid stays 0, buffer empty, MEM_allow_in=1.
